// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has fixed priority.
// A multi-cycle unit result that waits too long forces a one-cycle pipeline stall.
module wb_port_arbiter #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_dest,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               grant_wb_c, grant_mc_c, mc_ready_c;
  logic [ADDR_W-1:0]  sel_dest_c;
  logic [DATA_W-1:0]  sel_data_c;

  // State and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grant selection, next state and starvation bookkeeping
  always_comb begin
    state_d    = ST_NORMAL;
    wait_cnt_d = '0;
    grant_wb_c = 1'b0;
    grant_mc_c = 1'b0;
    mc_ready_c = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        mc_ready_c = ~wb_valid;
        if (wb_valid) begin
          grant_wb_c = 1'b1;
          if (mc_valid) begin
            wait_cnt_d = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q
                                                       : wait_cnt_q + CNT_W'(1);
            if (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = ST_FORCE;
          end
        end else begin
          grant_mc_c = mc_valid;
        end
      end
      ST_FORCE: begin
        mc_ready_c = 1'b1;
        grant_mc_c = mc_valid;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  assign sel_dest_c = grant_wb_c ? wb_dest : mc_dest;
  assign sel_data_c = grant_wb_c ? wb_data : mc_data;

  // Handshake is suppressed while reset is asserted
  assign mc_ready = rst_n & mc_ready_c;

  // Registered write port; R0 writes complete the handshake but never pulse rf_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pipe_stall <= 1'b0;
    end else begin
      rf_we      <= (grant_wb_c | grant_mc_c) & (sel_dest_c != '0);
      pipe_stall <= (state_d == ST_FORCE);
      if (grant_wb_c | grant_mc_c) begin
        rf_waddr <= sel_dest_c;
        rf_wdata <= sel_data_c;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queued directed and random traffic, a starvation
// reference model, and a scoreboard of per-cycle expected register-file writes.
module tb_wb_port_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned LIMIT  = 4;

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] d;
    logic [DATA_W-1:0] x;
  } item_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_valid = 1'b0, mc_valid = 1'b0;
  logic [ADDR_W-1:0] wb_dest = '0, mc_dest = '0;
  logic [DATA_W-1:0] wb_data = '0, mc_data = '0;
  logic              mc_ready, pipe_stall, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_data(mc_data),
    .mc_ready(mc_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  item_t wb_q[$];
  item_t mc_q[$];
  exp_t  exp_q[$];
  bit    hold_rst = 1'b1;
  bit    wb_acc = 1'b1, mc_acc = 1'b1;
  int    streak = 0;
  bit    forced_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pipeline wins unless the mc result has already been
  // passed over LIMIT times in a row, in which case the next cycle belongs to mc.
  always @(negedge clk) begin
    exp_t e;
    bit   win_wb, win_mc, exp_rdy, exp_stall;
    if (!rst_n) begin
      streak = 0; forced_next = 1'b0;
      wb_acc = 1'b1; mc_acc = 1'b1;
      exp_q.delete();
    end else begin
      win_wb = 1'b0; win_mc = 1'b0;
      exp_stall = forced_next;
      if (forced_next) begin
        exp_rdy = 1'b1;
        win_mc = mc_valid;
        forced_next = 1'b0;
        streak = 0;
      end else begin
        exp_rdy = !wb_valid;
        if (wb_valid) begin
          win_wb = 1'b1;
          if (mc_valid) begin
            streak++;
            if (streak >= int'(LIMIT)) forced_next = 1'b1;
          end else streak = 0;
        end else begin
          win_mc = mc_valid;
          streak = 0;
        end
      end
      chk("pipe_stall", 32'(pipe_stall), 32'(exp_stall));
      chk("mc_ready", 32'(mc_ready), 32'(exp_rdy));
      wb_acc = win_wb;
      mc_acc = win_mc;
      e.addr = win_wb ? wb_dest : mc_dest;
      e.data = win_wb ? wb_data : mc_data;
      e.we   = (win_wb || win_mc) && (e.addr != '0);
      exp_q.push_back(e);
    end
  end

  // Monitor: one scoreboard entry retires per cycle, just after the write edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rf_we", 32'(rf_we), 32'(e.we));
          if (e.we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
          end
        end else if (rf_we) begin
          chk("unexpected_write", 32'(rf_we), 32'd0);
        end
      end
    end
  end

  // Driver: holds an item until the model says it was accepted; bubbles last one cycle
  initial begin
    item_t it;
    forever begin
      @(posedge clk); #1;
      if (hold_rst) begin
        wb_valid = 1'b0; mc_valid = 1'b0;
      end else begin
        if (!wb_valid || wb_acc) begin
          if (wb_q.size() > 0) begin
            it = wb_q.pop_front();
            wb_valid = it.v; wb_dest = it.d; wb_data = it.x;
          end else wb_valid = 1'b0;
        end
        if (!mc_valid || mc_acc) begin
          if (mc_q.size() > 0) begin
            it = mc_q.pop_front();
            mc_valid = it.v; mc_dest = it.d; mc_data = it.x;
          end else mc_valid = 1'b0;
        end
      end
    end
  end

  task automatic push_wb(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x);
    item_t it;
    it.v = v; it.d = d; it.x = x;
    wb_q.push_back(it);
  endtask

  task automatic push_mc(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x);
    item_t it;
    it.v = v; it.d = d; it.x = x;
    mc_q.push_back(it);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      push_wb(($urandom % 4) != 0, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      push_mc(($urandom % 3) == 0, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
    end
  endtask

  task automatic drain(input string name, input int budget);
    int  cyc;
    bit  done;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      @(posedge clk); #2;
      done = (wb_q.size() == 0) && (mc_q.size() == 0) && !wb_valid && !mc_valid;
      cyc++;
    end
    repeat (3) @(posedge clk);
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rst_mc_ready", 32'(mc_ready), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_values();
    rst_n = 1'b1; hold_rst = 1'b0;
    repeat (2) @(posedge clk);

    push_wb(1'b1, 3'd3, 16'hBEEF);
    drain("drain_wb_basic", 50);
    push_mc(1'b1, 3'd5, 16'h1234);
    drain("drain_mc_basic", 50);

    push_mc(1'b1, 3'd6, 16'hAAAA);
    for (int i = 0; i < 6; i++) push_wb(1'b1, ADDR_W'(i + 1), DATA_W'(16'h0100 + i));
    drain("drain_starve", 50);

    push_wb(1'b1, 3'd0, 16'hFFFF);
    drain("drain_wb_r0", 50);
    push_mc(1'b1, 3'd0, 16'h5555);
    drain("drain_mc_r0", 50);

    push_mc(1'b1, 3'd2, 16'h0002);
    for (int i = 0; i < 6; i++) push_wb(1'b1, 3'd2, 16'h0001);
    drain("drain_same_dest", 50);

    push_random(200);
    repeat (60) @(posedge clk);
    #2;
    rst_n = 1'b0; hold_rst = 1'b1;
    #1;
    check_reset_values();
    wb_q.delete(); mc_q.delete();
    repeat (2) @(posedge clk);
    #2;
    check_reset_values();
    rst_n = 1'b1; hold_rst = 1'b0;

    push_random(300);
    drain("drain_random", 3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
